data_write_buffer: RTL

- Posted-store FIFO between the CPU store port and the single-ported data memory.
- Stores retire to the buffer in one cycle. The buffer drains to data_mem when the memory port is not needed by a CPU load.
- A load that hits a pending store's word address stalls until the buffer drains. A fence stalls until the buffer is empty.
- Sits between riscv_cpu store outputs and data_mem write inputs, after address decode qualifies the data-memory region.

---
 rtl/data_write_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/data_write_buffer.sv
// Posted-store FIFO between the CPU store port and single-ported data memory.
// Loads own the memory port unless they hit a pending store; fences wait for empty.
module data_write_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0]        cpu_wr_addr,
  input  logic [DATA_WIDTH-1:0]        cpu_wr_data,
  input  logic [3:0]                   cpu_wr_be,
  input  logic                         cpu_rd_en,
  input  logic [ADDR_WIDTH-1:0]        cpu_rd_addr,
  input  logic                         fence_req,
  output logic                         cpu_stall,
  output logic                         mem_wr_en,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  output logic [3:0]                   mem_wr_be,
  input  logic                         mem_ready,
  output logic                         buf_empty,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [3:0]            r_be   [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic w_rd_match;
  logic w_rd_hazard;
  logic w_empty;
  logic w_full;
  logic w_deq;
  logic w_accept;
  logic w_fence_stall;

  // Word-granular match: low two address bits and byte enables are ignored.
  always_comb begin
    w_rd_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (((r_addr[i] ^ cpu_rd_addr) >> 2) == '0))
        w_rd_match = 1'b1;
    end
  end

  assign w_rd_hazard   = cpu_rd_en && w_rd_match;
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == FULL_CNT);
  assign w_fence_stall = fence_req && !w_empty;

  assign mem_wr_en   = !w_empty && (!cpu_rd_en || w_rd_hazard);
  assign mem_wr_addr = r_addr[r_head];
  assign mem_wr_data = r_data[r_head];
  assign mem_wr_be   = r_be[r_head];

  assign w_deq    = mem_wr_en && mem_ready;
  assign w_accept = cpu_wr_en && (!w_full || w_deq) && !w_fence_stall;

  assign cpu_stall = (cpu_wr_en && w_full && !w_deq) || w_rd_hazard || w_fence_stall;
  assign buf_empty = w_empty;
  assign buf_count = r_count;

  // When full, enqueue and dequeue hit the same slot; the enqueue set must win.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_accept) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      case ({w_accept, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_addr[r_tail] <= cpu_wr_addr;
      r_data[r_tail] <= cpu_wr_data;
      r_be[r_tail]   <= cpu_wr_be;
    end
  end

endmodule
